// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// The host drives the byte stream through the master modport. The loader
// sits on the slave modport, accepts the stream and writes instruction
// memory.
interface prog_loader_if #(
    parameter int AW = 10
);
    logic          load_start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output load_start, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, busy, done, err
    );

    modport slave (
        input  load_start, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader. It frames a host byte stream (count, words, XOR checksum)
// into 16-bit instruction words and writes them to consecutive addresses,
// starting at address 0. It keeps the processor in reset until a load
// finishes with a good checksum.
module prog_loader #(
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);
    localparam int          DW    = 16;
    localparam logic [31:0] MAX_N = 32'd1 << AW;
    localparam logic [AW:0] ONE   = 1;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   idxNext;
    logic [7:0]    cntHi_q, cntHi_d;
    logic [7:0]    hiByte_q, hiByte_d;
    logic [7:0]    chk_q, chk_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cpuReset_q, cpuReset_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [31:0]   nWide;
    logic          readyInt;
    logic          xfer;

    assign readyInt = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                      (state_q == DAT_HI) || (state_q == DAT_LO) ||
                      (state_q == CHK);
    assign xfer     = readyInt && bus.byte_valid;
    assign idxNext  = idx_q + ONE;
    assign nWide    = {16'd0, cntHi_q, bus.byte_in};

    assign bus.byte_ready = readyInt;
    assign bus.busy       = (state_q != IDLE);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_reset  = cpuReset_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

    // Frame decoder: advances one field per accepted byte and builds the write and checksum.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        cntHi_d    = cntHi_q;
        hiByte_d   = hiByte_q;
        chk_d      = chk_q;
        done_d     = done_q;
        err_d      = err_q;
        cpuReset_d = cpuReset_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    idx_d      = '0;
                    chk_d      = '0;
                    cpuReset_d = 1'b1;
                    state_d    = CNT_HI;
                end
            end
            CNT_HI: begin
                if (xfer) begin
                    cntHi_d = bus.byte_in;
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    if (nWide > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        cnt_d   = nWide[AW:0];
                        state_d = (nWide == 32'd0) ? CHK : DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (xfer) begin
                    hiByte_d = bus.byte_in;
                    chk_d    = chk_q ^ bus.byte_in;
                    state_d  = DAT_LO;
                end
            end
            DAT_LO: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[AW-1:0];
                    wdata_d = {hiByte_q, bus.byte_in};
                    chk_d   = chk_q ^ bus.byte_in;
                    idx_d   = idxNext;
                    state_d = (idxNext == cnt_q) ? CHK : DAT_HI;
                end
            end
            CHK: begin
                if (xfer) begin
                    err_d   = (bus.byte_in != chk_q);
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d     = 1'b1;
                cpuReset_d = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset holds the processor in reset with no load pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            cntHi_q    <= '0;
            hiByte_q   <= '0;
            chk_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpuReset_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cntHi_q    <= cntHi_d;
            hiByte_q   <= hiByte_d;
            chk_q      <= chk_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpuReset_q <= cpuReset_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule
